// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: ROB-head handshake and register-file commit bus.
// master = ROB / environment side, slave = commit_ctrl.
interface commit_ctrl_if #(
    parameter int ROB_BIT = 4
);
    logic               head_valid;
    logic [4:0]         head_rd;
    logic [31:0]        head_data;
    logic [ROB_BIT-1:0] head_entry;
    logic               head_flush;
    logic [31:0]        head_target;
    logic               head_ready;

    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               rob_clear_up;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               issue_stall;

    modport master (
        output head_valid, head_rd, head_data, head_entry, head_flush, head_target,
        input  head_ready, commit_reg_id, commit_reg_data, commit_rob_entry,
               rob_clear_up, redirect_valid, redirect_pc, issue_stall
    );

    modport slave (
        input  head_valid, head_rd, head_data, head_entry, head_flush, head_target,
        output head_ready, commit_reg_id, commit_reg_data, commit_rob_entry,
               rob_clear_up, redirect_valid, redirect_pc, issue_stall
    );
endinterface

// File: rtl/commit_ctrl.sv
// commit_ctrl: pops one committed instruction per cycle from the ROB head,
// drives the register-file commit port, and sequences mispredict flushes.
// Optional feature macro: COMMIT_PERF_EN adds commit/flush performance counters.
//
// state | meaning
// RUN   | normal commit, head_ready follows rdy_in
// WB    | flushing instruction's result on the commit port
// CLEAR | rob_clear_up / redirect_valid pulse (one active cycle)
// DRAIN | issue held stalled while the drain counter runs down
module commit_ctrl #(
    parameter int ROB_BIT      = 4,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    commit_ctrl_if.slave bus
`ifdef COMMIT_PERF_EN
    ,
    output logic [31:0] perf_commit_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WB    = 2'd1,
        CLEAR = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Counter load value; zero-drain builds skip DRAIN entirely.
    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [4:0]         id_q, id_d;
    logic [31:0]        data_q, data_d;
    logic [ROB_BIT-1:0] entry_q, entry_d;
    logic [31:0]        target_q, target_d;
    logic               clear_q, clear_d;
    logic               redir_v_q, redir_v_d;
    logic [31:0]        redir_pc_q, redir_pc_d;
    logic               accept;

    assign bus.head_ready = (state_q == RUN) && rdy_in;
    assign accept         = bus.head_valid && bus.head_ready;

    // Next-state and next-output computation for the flush sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        data_d     = data_q;
        entry_d    = entry_q;
        target_d   = target_q;
        clear_d    = clear_q;
        redir_v_d  = redir_v_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    id_d    = bus.head_rd;
                    data_d  = bus.head_data;
                    entry_d = bus.head_entry;
                    if (bus.head_flush) begin
                        target_d = bus.head_target;
                        state_d  = WB;
                    end
                end else begin
                    id_d    = '0;
                    data_d  = '0;
                    entry_d = '0;
                end
            end
            WB: begin
                // Commit port goes quiet so the clear never coincides with a write.
                id_d       = '0;
                data_d     = '0;
                entry_d    = '0;
                clear_d    = 1'b1;
                redir_v_d  = 1'b1;
                redir_pc_d = target_q;
                state_d    = CLEAR;
            end
            CLEAR: begin
                clear_d   = 1'b0;
                redir_v_d = 1'b0;
                if (DRAIN_CYCLES > 0) begin
                    cnt_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            id_q       <= '0;
            data_q     <= '0;
            entry_q    <= '0;
            target_q   <= '0;
            clear_q    <= 1'b0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            data_q     <= data_d;
            entry_q    <= entry_d;
            target_q   <= target_d;
            clear_q    <= clear_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign bus.commit_reg_id    = id_q;
    assign bus.commit_reg_data  = data_q;
    assign bus.commit_rob_entry = entry_q;
    assign bus.rob_clear_up     = clear_q;
    assign bus.redirect_valid   = redir_v_q;
    assign bus.redirect_pc      = redir_pc_q;
    assign bus.issue_stall      = (state_q != RUN);

`ifdef COMMIT_PERF_EN
    // Accept and flush-accept counters, wrapping modulo 2^32.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (accept) begin
            perf_commit_cnt <= perf_commit_cnt + 32'd1;
            if (bus.head_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed + randomized bench for commit_ctrl with a
// time-indexed reference model (counts active clock edges, no state machine).
module tb_commit_ctrl;
    localparam int ROB_BIT = 4;
    localparam int D       = 1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;

    commit_ctrl_if #(.ROB_BIT(ROB_BIT)) bus ();

`ifdef COMMIT_PERF_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    commit_ctrl #(.ROB_BIT(ROB_BIT), .DRAIN_CYCLES(D)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef COMMIT_PERF_EN
        ,
        .perf_commit_cnt (perf_commit_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: t counts active edges; a flush accepted at edge f
    // makes the block busy after edges f..f+1+D and pulses clear after edge f+1.
    int          t, flush_t;
    logic [4:0]  e_id;
    logic [31:0] e_data;
    logic [3:0]  e_entry;
    logic [31:0] e_target, e_rpc;
    logic        e_clr;
    bit          last_acc;
    logic [31:0] e_ccnt, e_fcnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic bit m_busy();
        return (t >= flush_t) && (t <= flush_t + 1 + D);
    endfunction

    task automatic model_reset();
        t = 0; flush_t = -100;
        e_id = '0; e_data = '0; e_entry = '0; e_target = '0; e_rpc = '0;
        e_clr = 1'b0; last_acc = 0; e_ccnt = '0; e_fcnt = '0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = bus.head_valid && !m_busy();
        t++;
        if (acc) begin
            e_id = bus.head_rd; e_data = bus.head_data; e_entry = bus.head_entry;
            e_ccnt = e_ccnt + 32'd1;
            if (bus.head_flush) begin
                flush_t  = t;
                e_target = bus.head_target;
                e_fcnt   = e_fcnt + 32'd1;
            end
        end else begin
            e_id = '0; e_data = '0; e_entry = '0;
        end
        e_clr = (t == flush_t + 1);
        if (e_clr) e_rpc = e_target;
        last_acc = acc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("head_ready",   32'(bus.head_ready),       32'(rdy_in && !m_busy()));
        chk("issue_stall",  32'(bus.issue_stall),      32'(m_busy()));
        chk("commit_id",    32'(bus.commit_reg_id),    32'(e_id));
        chk("commit_data",  bus.commit_reg_data,       e_data);
        chk("commit_entry", 32'(bus.commit_rob_entry), 32'(e_entry));
        chk("rob_clear_up", 32'(bus.rob_clear_up),     32'(e_clr));
        chk("redir_valid",  32'(bus.redirect_valid),   32'(e_clr));
        chk("redir_pc",     bus.redirect_pc,           e_rpc);
`ifdef COMMIT_PERF_EN
        chk("perf_commit",  perf_commit_cnt,           e_ccnt);
        chk("perf_flush",   perf_flush_cnt,            e_fcnt);
`endif
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] data,
                         input logic [3:0] entry, input logic fl, input logic [31:0] tgt);
        bus.head_valid = v; bus.head_rd = rd; bus.head_data = data;
        bus.head_entry = entry; bus.head_flush = fl; bus.head_target = tgt;
    endtask

    task automatic step();
        @(posedge clk_in);
        if (rst_in && rdy_in) model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);

        // Reset: everything zero, ready once rdy_in is high.
        #12;
        check_all();
        rdy_in = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.head_ready), 32'd1);
        check_all();
        @(negedge clk_in);
        rst_in = 1'b1;
        step(); step();

        // Three back-to-back commits.
        drive(1, 5, 32'h11, 1, 0, 0); step();
        chk("b2b_id0", 32'(bus.commit_reg_id), 32'd5);
        drive(1, 6, 32'h22, 2, 0, 0); step();
        chk("b2b_id1", 32'(bus.commit_reg_id), 32'd6);
        drive(1, 0, 32'h33, 3, 0, 0); step();
        chk("b2b_id2", 32'(bus.commit_reg_id), 32'd0);
        chk("b2b_data2", bus.commit_reg_data, 32'h33);
        drive(0, 0, 0, 0, 0, 0); step();

        // Flush commit; next head waits behind the sequence.
        drive(1, 1, 32'hAA, 7, 1, 32'h1000); step();
        chk("fl_wb_id", 32'(bus.commit_reg_id), 32'd1);
        chk("fl_wb_data", bus.commit_reg_data, 32'hAA);
        drive(1, 9, 32'h99, 8, 0, 0); step();
        chk("fl_clear", 32'(bus.rob_clear_up), 32'd1);
        chk("fl_pc", bus.redirect_pc, 32'h1000);
        chk("fl_id0", 32'(bus.commit_reg_id), 32'd0);
        step(); step();
        chk("fl_ready_back", 32'(bus.head_ready), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0); step();

        // rdy_in low during CLEAR freezes the pulse.
        drive(1, 2, 32'hBB, 4, 1, 32'h2000); step();
        drive(0, 0, 0, 0, 0, 0); step();
        rdy_in = 1'b0;
        repeat (4) step();
        chk("frz_clear", 32'(bus.rob_clear_up), 32'd1);
        rdy_in = 1'b1;
        step();
        chk("frz_clear_end", 32'(bus.rob_clear_up), 32'd0);
        repeat (3) step();

        // Asynchronous reset while draining.
        drive(1, 3, 32'hCC, 5, 1, 32'h3000); step();
        drive(0, 0, 0, 0, 0, 0); step(); step();
        #2 rst_in = 1'b0;
        #1 model_reset();
        check_all();
        step();
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) step();

        // Ten accepted commits, two of them flushes.
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(i + 1), 32'(i * 3), 4'(i), (i == 3 || i == 7), 32'h4000 + 32'(i));
            guard = 0;
            do begin
                step();
                guard++;
            end while (!last_acc && guard < 20);
            chk("perf_loop_acc", 32'(last_acc), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, 4'($urandom),
                  $urandom_range(0, 7) == 0, $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

Commit sequencer between the ROB head and the renaming register file. Pops at most one committed instruction per cycle, drives the register file's commit write port, and on a mispredict/flush commit runs a fixed sequence: write the flushing instruction's result, pulse `rob_clear_up`, redirect fetch, then hold issue stalled for a drain window. It is the only block that drives the register file's commit and clear inputs.

## Interface
- `ROB_BIT`, 4: ROB index width.
- `DRAIN_CYCLES`, 1: stall cycles after the clear pulse; legal range 0..15.

- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global ready; low freezes the block
- `head_valid`  in  1  ROB head is complete and may commit
- `head_rd`  in  5  destination register; 0 means no write
- `head_data`  in  32  result value
- `head_entry`  in  ROB_BIT  ROB index of the head
- `head_flush`  in  1  head needs pipeline flush (mispredict)
- `head_target`  in  32  correct PC for a flush
- `head_ready`  out  1  accept/pop strobe to ROB
- `commit_reg_id`  out  5  register file commit id (0 = no write)
- `commit_reg_data`  out  32  register file commit data
- `commit_rob_entry`  out  ROB_BIT  register file commit tag
- `rob_clear_up`  out  1  clears ROB, RS, LSB and register file rename state
- `redirect_valid`  out  1  fetch redirect strobe
- `redirect_pc`  out  32  fetch redirect target
- `issue_stall`  out  1  blocks decoder issue

## Operation
- States: RUN, WB, CLEAR, DRAIN. Reset state RUN.
- `head_ready` = (state==RUN) && `rdy_in`, combinational. Accept = `head_valid` && `head_ready`.
- `issue_stall` = (state!=RUN), combinational.
- RUN, accept: register `commit_reg_id`<=`head_rd`, data<=`head_data`, tag<=`head_entry`; if `head_flush`, latch `head_target`, go WB; else stay RUN.
- RUN, no accept: commit outputs <= 0.
- WB: commit outputs hold the flushing write; next -> CLEAR with commit outputs <= 0, `rob_clear_up`<=1, `redirect_valid`<=1, `redirect_pc`<=latched target.
- CLEAR: one cycle; next -> DRAIN with counter loaded to DRAIN_CYCLES-1 if DRAIN_CYCLES>0, else -> RUN; `rob_clear_up`, `redirect_valid` <= 0.
- DRAIN: counter decrements; at 0 -> RUN.
- `head_rd`==0 commit: id 0 driven, data/tag still driven; no flush side effect unless `head_flush`.
- `rdy_in` low: all registers hold, including state, counter, and pulse outputs.
- All registered outputs reset to 0; `redirect_pc` resets to 0.

## Timing
- Commit latency: accept at edge E0 -> commit outputs valid in cycle E0..E1 -> register file write at E1.
- Back-to-back commits: one per cycle in RUN, no bubbles.
- Flush: accept E0; flushing write visible E0..E1 (state WB); `rob_clear_up`/`redirect_valid` high exactly one cycle E1..E2; never asserted together with nonzero `commit_reg_id`, because the register file discards commits during a clear.
- `head_ready` low from E0+ through end of DRAIN; the first new accept is possible at E(3+DRAIN_CYCLES).
- Asynchronous reset mid-sequence: immediately RUN, all outputs 0; no clear pulse emitted.

## Configuration
- `COMMIT_PERF_EN` defined: adds outputs `perf_commit_cnt` (32) and `perf_flush_cnt` (32). They count accepts and flush accepts, reset to 0, wrap modulo 2^32, and freeze when `rdy_in` is low.
- Not defined: ports and counters absent; the rest of the behaviour is identical.

## Test plan
- Reset: hold `rst_in`=0 -> all outputs 0, `head_ready`=1 once released with `rdy_in`=1.
- Three back-to-back commits rd=5/6/0, data 0x11/0x22/0x33, entries 1/2/3 -> commit ids 5,6,0 on consecutive cycles one cycle after each accept; `head_ready` stays high.
- Flush commit rd=1, data 0xAA, entry 7, target 0x1000, DRAIN_CYCLES=1 -> WB cycle writes x1=0xAA; next cycle `rob_clear_up`=1, `redirect_pc`=0x1000, `commit_reg_id`=0; `head_ready` low for 3 cycles, then high.
- `rdy_in` dropped during CLEAR for 4 cycles -> `rob_clear_up` stays high and the state is frozen; after `rdy_in` returns, exactly one more clear cycle.
- `rst_in` asserted in DRAIN -> immediate RUN, `issue_stall`=0, no further redirect.
- With `COMMIT_PERF_EN`: 10 commits including 2 flushes -> `perf_commit_cnt`=10, `perf_flush_cnt`=2.
